mem_access_guard: RTL and testbench

MEM_ACCESS_GUARD -- requirements
Module: mem_access_guard

---
 rtl/mem_access_guard_pkg.sv | 68 ++++++
 rtl/mem_access_guard_region_match.sv | 25 ++
 rtl/mem_access_guard.sv | 168 ++++++++++++++++
 tb/tb_mem_access_guard.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_guard_pkg.sv
// Shared encodings and default address windows
// for the M-stage memory access guard.
package mem_access_guard_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'b00,
    ACC_LOAD  = 2'b01,
    ACC_STORE = 2'b10,
    ACC_RSVD  = 2'b11
  } acc_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int ATTR_RD = 0;
  localparam int ATTR_WR = 1;
  localparam int ATTR_WO = 2;

  localparam int MAX_REGIONS = 16;

  function automatic logic [31:0] def_base(
    input int i
  );
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h0000_7F08;
      2:       return 32'h0000_7F00;
      3:       return 32'h0000_7F18;
      4:       return 32'h0000_7F10;
      default: return 32'h0000_0001;
    endcase
  endfunction

  function automatic logic [31:0] def_limit(
    input int i
  );
    case (i)
      0:       return 32'h0000_2FFF;
      1:       return 32'h0000_7F0B;
      2:       return 32'h0000_7F07;
      3:       return 32'h0000_7F1B;
      4:       return 32'h0000_7F17;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [2:0] def_attr(
    input int i
  );
    case (i)
      0:       return 3'b011;
      1:       return 3'b101;
      2:       return 3'b111;
      3:       return 3'b101;
      4:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_guard_region_match.sv
// One address window: inclusive unsigned bounds
// plus its permission attributes.
module region_match
  import mem_access_guard_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] limit_i,
  input  logic [2:0]        attr_i,
  output logic              hit_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic              wo_o
);

  // base > limit can never satisfy both bounds
  assign hit_o = (addr_i >= base_i) &&
                 (addr_i <= limit_i);
  assign rd_o  = attr_i[ATTR_RD];
  assign wr_o  = attr_i[ATTR_WR];
  assign wo_o  = attr_i[ATTR_WO];

endmodule

// File: rtl/mem_access_guard.sv
// M-stage address/permission guard: raises AdEL/AdES,
// latches the first bad address and counts faults.
module mem_access_guard
  import mem_access_guard_pkg::*;
#(
  parameter int NUM_REGIONS = 5,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        acc,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        exc_prev,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_limit,
  input  logic [2:0]        cfg_attr,
  input  logic              exc_ack,
  output logic              out_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] bad_vaddr,
  output logic              bad_vaddr_valid,
  output logic [CNT_W-1:0]  fault_cnt
);

  logic [ADDR_W-1:0] base_q  [NUM_REGIONS];
  logic [ADDR_W-1:0] limit_q [NUM_REGIONS];
  logic [2:0]        attr_q  [NUM_REGIONS];

  logic [NUM_REGIONS-1:0] hit, rd, wr, wo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base_q[i]  <= ADDR_W'(def_base(i));
        limit_q[i] <= ADDR_W'(def_limit(i));
        attr_q[i]  <= def_attr(i);
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (cfg_idx == 4'(i)) begin
          base_q[i]  <= cfg_base;
          limit_q[i] <= cfg_limit;
          attr_q[i]  <= cfg_attr;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rm
    region_match #(
      .ADDR_W (ADDR_W)
    ) u_rm (
      .addr_i  (addr),
      .base_i  (base_q[g]),
      .limit_i (limit_q[g]),
      .attr_i  (attr_q[g]),
      .hit_o   (hit[g]),
      .rd_o    (rd[g]),
      .wr_o    (wr[g]),
      .wo_o    (wo[g])
    );
  end

  logic found, sel_rd, sel_wr, sel_wo;

  always_comb begin
    found  = 1'b0;
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    sel_wo = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found && hit[i]) begin
        found  = 1'b1;
        sel_rd = rd[i];
        sel_wr = wr[i];
        sel_wo = wo[i];
      end
    end
  end

  logic is_ld, is_st, is_word, mis;
  logic perm_ok, bad, addr_fault;
  logic [4:0] code_c;

  assign is_ld = (acc == ACC_LOAD);
  assign is_st = (acc == ACC_STORE);

  always_comb begin
    is_word = 1'b0;
    mis     = 1'b0;
    unique case (1'b1)
      (size == SZ_HALF): mis = addr[0];
      (size == SZ_BYTE): mis = 1'b0;
      default: begin
        is_word = 1'b1;
        mis     = |addr[1:0];
      end
    endcase
  end

  assign perm_ok = is_ld ? sel_rd : sel_wr;
  assign bad = mis | ~found | ~perm_ok |
               (sel_wo & ~is_word);
  assign addr_fault = (is_ld | is_st) &
                      (exc_prev == EXC_NONE) & bad;
  assign code_c = !addr_fault ? exc_prev :
                  is_ld ? EXC_ADEL : EXC_ADES;

  logic              valid_q, valid_d;
  logic [4:0]        code_q, code_d;
  logic [ADDR_W-1:0] bva_q, bva_d;
  logic              bvv_q, bvv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign accept = ~stall & ~flush & in_valid &
                  addr_fault;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    bva_d   = bva_q;
    bvv_d   = bvv_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      valid_d = in_valid & ~flush;
      code_d  = flush ? EXC_NONE : code_c;
    end
    // ack in the same cycle as a fault frees the slot
    if (accept) begin
      bvv_d = 1'b1;
      if (!bvv_q || exc_ack) bva_d = addr;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (exc_ack) begin
      bvv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      code_q  <= EXC_NONE;
      bva_q   <= '0;
      bvv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      bva_q   <= bva_d;
      bvv_q   <= bvv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid       = valid_q;
  assign exc_code        = code_q;
  assign bad_vaddr       = bva_q;
  assign bad_vaddr_valid = bvv_q;
  assign fault_cnt       = cnt_q;

endmodule

// File: tb/tb_mem_access_guard.sv
// Bench for mem_access_guard: vector table, directed
// corner sequences and random traffic vs. a model.
module tb_mem_access_guard;

  localparam int NR = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [1:0]  acc, size;
  logic [31:0] addr;
  logic [4:0]  exc_prev;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_base, cfg_limit;
  logic [2:0]  cfg_attr;
  logic        exc_ack;
  logic        out_valid;
  logic [4:0]  exc_code;
  logic [31:0] bad_vaddr;
  logic        bad_vaddr_valid;
  logic [7:0]  fault_cnt;

  mem_access_guard #(
    .NUM_REGIONS (NR),
    .ADDR_W      (32),
    .CNT_W       (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .stall           (stall),
    .flush           (flush),
    .acc             (acc),
    .size            (size),
    .addr            (addr),
    .exc_prev        (exc_prev),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_base        (cfg_base),
    .cfg_limit       (cfg_limit),
    .cfg_attr        (cfg_attr),
    .exc_ack         (exc_ack),
    .out_valid       (out_valid),
    .exc_code        (exc_code),
    .bad_vaddr       (bad_vaddr),
    .bad_vaddr_valid (bad_vaddr_valid),
    .fault_cnt       (fault_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference state
  longint mb [NR];
  longint ml [NR];
  int     ma [NR];
  int     m_v, m_code, m_bvv, m_cnt;
  longint m_bva;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    longint b[5] = '{'h0, 'h7F08, 'h7F00,
                     'h7F18, 'h7F10};
    longint l[5] = '{'h2FFF, 'h7F0B, 'h7F07,
                     'h7F1B, 'h7F17};
    int a[5] = '{3, 5, 7, 5, 7};
    for (int i = 0; i < NR; i++) begin
      mb[i] = b[i];
      ml[i] = l[i];
      ma[i] = a[i];
    end
    m_v = 0; m_code = 0; m_bva = 0;
    m_bvv = 0; m_cnt = 0;
  endfunction

  function automatic int ref_code(
    output bit flt);
    int align, hit;
    bit ld, st, bad;
    longint a;
    a = longint'(addr);
    flt = 0;
    ld = (acc == 2'd1);
    st = (acc == 2'd2);
    if (!ld && !st) return int'(exc_prev);
    align = (size == 2'd1) ? 2 :
            (size == 2'd2) ? 1 : 4;
    hit = -1;
    for (int i = 0; i < NR; i++)
      if (hit < 0 && mb[i] <= a && a <= ml[i])
        hit = i;
    bad = (a % align) != 0 || hit < 0;
    if (!bad) begin
      if (ld && ma[hit][0] == 0) bad = 1;
      if (st && ma[hit][1] == 0) bad = 1;
      if (ma[hit][2] == 1 && align != 4) bad = 1;
    end
    if (exc_prev != 0) return int'(exc_prev);
    flt = bad;
    return bad ? (ld ? 4 : 5) : 0;
  endfunction

  function automatic void model_step();
    bit flt, took;
    int c;
    c = ref_code(flt);
    took = 0;
    if (!stall) begin
      m_v    = (in_valid && !flush) ? 1 : 0;
      m_code = flush ? 0 : c;
      took   = !flush && in_valid && flt;
    end
    if (took) begin
      if (!m_bvv || exc_ack) m_bva = longint'(addr);
      m_bvv = 1;
      if (m_cnt < 255) m_cnt++;
    end else if (exc_ack) begin
      m_bvv = 0;
    end
    if (cfg_we && cfg_idx < NR) begin
      mb[cfg_idx] = longint'(cfg_base);
      ml[cfg_idx] = longint'(cfg_limit);
      ma[cfg_idx] = int'(cfg_attr);
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, out_valid, m_v);
    chk({tag, ".exc_code"}, exc_code, m_code);
    chk({tag, ".bad_vaddr"}, bad_vaddr, m_bva);
    chk({tag, ".bvv"}, bad_vaddr_valid, m_bvv);
    chk({tag, ".fault_cnt"}, fault_cnt, m_cnt);
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; flush = 0;
    acc = 0; size = 0; addr = 0; exc_prev = 0;
    cfg_we = 0; cfg_idx = 0; cfg_base = 0;
    cfg_limit = 0; cfg_attr = 0; exc_ack = 0;
  endtask

  task automatic op(input logic [1:0] a,
                    input logic [1:0] s,
                    input logic [31:0] ad);
    idle();
    in_valid = 1; acc = a; size = s; addr = ad;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("rst");
    reset = 1;
    #1;
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [1:0]  s;
    logic [31:0] ad;
    logic [4:0]  prev;
    logic        iv;
    logic        fl;
    logic [4:0]  ecode;
    logic        evalid;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{2'd1, 2'd0, 32'h1002, 5'd0, 1, 0, 5'd4, 1};
    tbl[1]  = '{2'd2, 2'd0, 32'h7F08, 5'd0, 1, 0, 5'd5, 1};
    tbl[2]  = '{2'd1, 2'd0, 32'h7F08, 5'd0, 1, 0, 5'd0, 1};
    tbl[3]  = '{2'd1, 2'd1, 32'h7F00, 5'd0, 1, 0, 5'd4, 1};
    tbl[4]  = '{2'd2, 2'd2, 32'h7F01, 5'd0, 1, 0, 5'd5, 1};
    tbl[5]  = '{2'd1, 2'd0, 32'h2FFC, 5'd0, 1, 0, 5'd0, 1};
    tbl[6]  = '{2'd2, 2'd0, 32'h2FFC, 5'd0, 1, 0, 5'd0, 1};
    tbl[7]  = '{2'd1, 2'd0, 32'h3000, 5'd0, 1, 0, 5'd4, 1};
    tbl[8]  = '{2'd0, 2'd0, 32'h3001, 5'd0, 1, 0, 5'd0, 1};
    tbl[9]  = '{2'd3, 2'd0, 32'h3001, 5'd3, 1, 0, 5'd3, 1};
    tbl[10] = '{2'd2, 2'd0, 32'h0002, 5'd10, 1, 0, 5'd10, 1};
    tbl[11] = '{2'd1, 2'd2, 32'h0001, 5'd0, 1, 0, 5'd0, 1};
    tbl[12] = '{2'd1, 2'd1, 32'h0003, 5'd0, 1, 0, 5'd4, 1};
    tbl[13] = '{2'd1, 2'd3, 32'h0002, 5'd0, 1, 0, 5'd4, 1};
    tbl[14] = '{2'd1, 2'd0, 32'h0000, 5'd0, 0, 0, 5'd0, 0};
    tbl[15] = '{2'd1, 2'd0, 32'h3000, 5'd0, 1, 1, 5'd0, 0};
  end

  initial begin
    reset = 0;
    idle();
    #1;
    chk("async_rst.out_valid", out_valid, 0);
    do_reset();

    // vector table
    for (int i = 0; i < 16; i++) begin
      op(tbl[i].a, tbl[i].s, tbl[i].ad);
      exc_prev = tbl[i].prev;
      in_valid = tbl[i].iv;
      flush    = tbl[i].fl;
      cyc($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.code", i),
          exc_code, tbl[i].ecode);
      chk($sformatf("vec%0d.valid", i),
          out_valid, tbl[i].evalid);
    end

    // first misaligned load
    do_reset();
    op(2'd1, 2'd0, 32'h1002);
    cyc("lw1002");
    chk("lw1002.code", exc_code, 4);
    chk("lw1002.bva", bad_vaddr, 32'h1002);
    chk("lw1002.bvv", bad_vaddr_valid, 1);
    chk("lw1002.cnt", fault_cnt, 1);

    // capture hold, then ack + new fault
    do_reset();
    op(2'd1, 2'd0, 32'h3000);
    cyc("f3000");
    op(2'd1, 2'd0, 32'h4000);
    cyc("f4000");
    chk("hold.bva", bad_vaddr, 32'h3000);
    chk("hold.cnt", fault_cnt, 2);
    op(2'd1, 2'd0, 32'h5000);
    exc_ack = 1;
    cyc("ackf");
    chk("ackf.bva", bad_vaddr, 32'h5000);
    chk("ackf.bvv", bad_vaddr_valid, 1);
    idle();
    exc_ack = 1;
    cyc("ack");
    chk("ack.bvv", bad_vaddr_valid, 0);

    // flush and exc_prev priority
    do_reset();
    op(2'd1, 2'd0, 32'h3000);
    flush = 1;
    cyc("flush");
    chk("flush.valid", out_valid, 0);
    chk("flush.bvv", bad_vaddr_valid, 0);
    op(2'd2, 2'd0, 32'h0002);
    exc_prev = 5'd10;
    cyc("prev");
    chk("prev.code", exc_code, 10);
    chk("prev.cnt", fault_cnt, 0);

    // stall holds outputs; stall+flush too
    op(2'd1, 2'd0, 32'h0000);
    cyc("pre_stall");
    op(2'd1, 2'd0, 32'h3000);
    stall = 1;
    cyc("stall");
    chk("stall.code", exc_code, 0);
    chk("stall.cnt", fault_cnt, 0);
    flush = 1;
    cyc("stallfl");
    chk("stallfl.valid", out_valid, 1);

    // config writes, same-cycle old entry
    idle();
    cfg_we = 1; cfg_idx = 0;
    cfg_base = 32'h10; cfg_limit = 32'hF;
    cfg_attr = 3'b011;
    in_valid = 1; acc = 2'd1;
    cyc("cfg_same");
    chk("cfg_same.code", exc_code, 0);
    op(2'd1, 2'd0, 32'h0000);
    cyc("cfg_new");
    chk("cfg_new.code", exc_code, 4);
    idle();
    cfg_we = 1; cfg_idx = 15;
    cfg_base = 0; cfg_limit = 32'hFFFF_FFFF;
    cfg_attr = 3'b111;
    cyc("cfg15");
    op(2'd1, 2'd0, 32'h0000);
    cyc("cfg15_chk");
    chk("cfg15.code", exc_code, 4);
    idle();
    stall = 1; cfg_we = 1; cfg_idx = 0;
    cfg_base = 0; cfg_limit = 32'h2FFF;
    cfg_attr = 3'b011;
    cyc("cfg_stall");
    op(2'd1, 2'd0, 32'h0000);
    cyc("cfg_stall_chk");
    chk("cfg_stall.code", exc_code, 0);

    // counter saturation, async reset in stall
    do_reset();
    for (int i = 0; i < 256; i++) begin
      op(2'd1, 2'd0, 32'h3000 + 32'(i * 4));
      cyc("sat");
    end
    chk("sat.cnt", fault_cnt, 255);
    chk("sat.bva", bad_vaddr, 32'h3000);
    op(2'd1, 2'd0, 32'h3000);
    stall = 1;
    @(posedge clk);
    #3;
    reset = 0;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.code", exc_code, 0);
    chk("arst.bva", bad_vaddr, 0);
    chk("arst.bvv", bad_vaddr_valid, 0);
    chk("arst.cnt", fault_cnt, 0);
    do_reset();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      in_valid = ($urandom_range(0, 9) != 0);
      acc  = 2'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: addr = 32'($urandom_range(0, 'h3003));
        1: addr = 32'h7EFC +
                  32'($urandom_range(0, 40));
        2: addr = $urandom;
        default: addr = 32'h7F00 +
                  32'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 5) == 0)
        exc_prev = 5'($urandom_range(1, 31));
      stall   = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      exc_ack = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 19) == 0) begin
        cfg_we    = 1;
        cfg_idx   = 4'($urandom_range(0, 15));
        cfg_base  = 32'($urandom_range(0, 'h7F20));
        cfg_limit = 32'($urandom_range(0, 'h7F20));
        cfg_attr  = 3'($urandom_range(0, 7));
      end
      cyc("rnd");
      if (n == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
